bf16_div: RTL and testbench

- Iterative bfloat16 divider (quot = a / b); the inverse operation to the team's combinational bf16 multiplier.
- Uses the same exception, overflow and underflow semantics as the multiplier: truncating, with denormals flushed to zero.
- Restoring division, one quotient bit per cycle, behind a start/ready/valid_out handshake.
- Sits beside the multiplier in the accelerator datapath.

---
 rtl/bf16_pkg.sv | 26 ++
 rtl/bf16_mant_div_step.sv | 25 ++
 rtl/bf16_div.sv | 187 ++++++++++++++++++
 tb/tb_bf16_div.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/bf16_pkg.sv
// Shared bfloat16 constants, FSM state type and exponent classification helpers
// for the iterative divider.
package bf16_pkg;

    localparam int EXP_W  = 8;
    localparam int MANT_W = 7;
    localparam int BIAS   = 127;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
    localparam int QW     = MANT_W + 2;
    localparam int SEXP_W = EXP_W + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2
    } state_e;

    function automatic logic is_special(input logic [EXP_W-1:0] e);
        return (e == EXP_MAX);
    endfunction

    function automatic logic is_zero(input logic [EXP_W-1:0] e);
        return (e == {EXP_W{1'b0}});
    endfunction

endpackage

// File: rtl/bf16_mant_div_step.sv
// One restoring-division step: subtract the divisor if it fits, emit the quotient
// bit and return the doubled partial remainder.
module bf16_mant_div_step
    import bf16_pkg::*;
(
    input  logic [QW-1:0]   rem_i,
    input  logic [MANT_W:0] mb_i,
    output logic            qbit_o,
    output logic [QW-1:0]   rem_next_o
);

    logic [QW:0] trial_s;

    // Trial subtraction; the borrow bit decides the quotient bit.
    always_comb begin
        trial_s = {1'b0, rem_i} - {2'b00, mb_i};
        qbit_o  = ~trial_s[QW];
        if (qbit_o) begin
            rem_next_o = trial_s[QW-1:0] << 1'b1;
        end else begin
            rem_next_o = rem_i << 1'b1;
        end
    end

endmodule

// File: rtl/bf16_div.sv
// Iterative bfloat16 divider: one quotient bit per cycle, truncating, denormals
// flushed to zero, fixed 11-cycle latency behind a start/ready handshake.
module bf16_div
    import bf16_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        ready,
    output logic        valid_out,
    output logic [15:0] quot,
    output logic        exception,
    output logic        div_by_zero,
    output logic        overflow,
    output logic        underflow
);

    state_e                    state_q, state_d;
    logic                      sign_q, sign_d;
    logic                      exc_q, exc_d;
    logic                      dz_q, dz_d;
    logic                      az_q, az_d;
    logic signed [SEXP_W-1:0]  exp_q, exp_d;
    logic [MANT_W:0]           mb_q, mb_d;
    logic [QW-1:0]             rem_q, rem_d;
    logic [QW-1:0]             q_q, q_d;
    logic [3:0]                cnt_q, cnt_d;
    logic                      ready_q, ready_d;
    logic                      valid_q, valid_d;
    logic [15:0]               quot_q, quot_d;
    logic                      exc_f_q, exc_f_d;
    logic                      dz_f_q, dz_f_d;
    logic                      of_f_q, of_f_d;
    logic                      uf_f_q, uf_f_d;

    logic                      qbit_s;
    logic [QW-1:0]             rem_next_s;
    logic signed [SEXP_W-1:0]  exp_n_s;
    logic [MANT_W-1:0]         mant_s;

    bf16_mant_div_step u_step (
        .rem_i      (rem_q),
        .mb_i       (mb_q),
        .qbit_o     (qbit_s),
        .rem_next_o (rem_next_s)
    );

    // Normalisation: a quotient below 1.0 costs one exponent step.
    always_comb begin
        if (q_q[QW-1]) begin
            exp_n_s = exp_q;
            mant_s  = q_q[QW-2:1];
        end else begin
            exp_n_s = exp_q - 10'sd1;
            mant_s  = q_q[MANT_W-1:0];
        end
    end

    // Next-state and result selection for the IDLE -> DIV -> NORM sequence.
    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        exc_d   = exc_q;
        dz_d    = dz_q;
        az_d    = az_q;
        exp_d   = exp_q;
        mb_d    = mb_q;
        rem_d   = rem_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        quot_d  = quot_q;
        exc_f_d = exc_f_q;
        dz_f_d  = dz_f_q;
        of_f_d  = of_f_q;
        uf_f_d  = uf_f_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DIV;
                    sign_d  = a[15] ^ b[15];
                    exc_d   = is_special(a[14:7]) || is_special(b[14:7]);
                    dz_d    = is_zero(b[14:7]);
                    az_d    = is_zero(a[14:7]);
                    exp_d   = $signed({2'b00, a[14:7]}) - $signed({2'b00, b[14:7]})
                              + $signed(SEXP_W'(BIAS));
                    mb_d    = {1'b1, b[6:0]};
                    rem_d   = {2'b01, a[6:0]};
                    q_d     = {QW{1'b0}};
                    cnt_d   = 4'd8;
                end else begin
                    state_d = IDLE;
                end
            end
            DIV: begin
                rem_d = rem_next_s;
                q_d   = {q_q[QW-2:0], qbit_s};
                if (cnt_q == 4'd0) begin
                    state_d = NORM;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            NORM: begin
                state_d = IDLE;
                valid_d = 1'b1;
                exc_f_d = 1'b0;
                dz_f_d  = 1'b0;
                of_f_d  = 1'b0;
                uf_f_d  = 1'b0;
                if (exc_q) begin
                    quot_d  = 16'h0000;
                    exc_f_d = 1'b1;
                end else if (dz_q) begin
                    quot_d = {sign_q, EXP_MAX, 7'd0};
                    dz_f_d = 1'b1;
                end else if (az_q) begin
                    quot_d = {sign_q, 15'd0};
                end else if (exp_n_s >= 10'sd255) begin
                    quot_d = {sign_q, EXP_MAX, 7'd0};
                    of_f_d = 1'b1;
                end else if (exp_n_s <= 10'sd0) begin
                    quot_d = {sign_q, 15'd0};
                    uf_f_d = 1'b1;
                end else begin
                    quot_d = {sign_q, exp_n_s[EXP_W-1:0], mant_s};
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            exc_q   <= 1'b0;
            dz_q    <= 1'b0;
            az_q    <= 1'b0;
            exp_q   <= 10'sd0;
            mb_q    <= 8'd0;
            rem_q   <= 9'd0;
            q_q     <= 9'd0;
            cnt_q   <= 4'd0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            quot_q  <= 16'h0000;
            exc_f_q <= 1'b0;
            dz_f_q  <= 1'b0;
            of_f_q  <= 1'b0;
            uf_f_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            exc_q   <= exc_d;
            dz_q    <= dz_d;
            az_q    <= az_d;
            exp_q   <= exp_d;
            mb_q    <= mb_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            quot_q  <= quot_d;
            exc_f_q <= exc_f_d;
            dz_f_q  <= dz_f_d;
            of_f_q  <= of_f_d;
            uf_f_q  <= uf_f_d;
        end
    end

    assign ready       = ready_q;
    assign valid_out   = valid_q;
    assign quot        = quot_q;
    assign exception   = exc_f_q;
    assign div_by_zero = dz_f_q;
    assign overflow    = of_f_q;
    assign underflow   = uf_f_q;

endmodule

// File: tb/tb_bf16_div.sv
// Bench for bf16_div: real-arithmetic reference model with a timing scoreboard
// checked every cycle, plus directed vectors with hand-computed results.
module tb_bf16_div;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] a, b;
    logic        ready, valid_out, exception, div_by_zero, overflow, underflow;
    logic [15:0] quot;
    logic [3:0]  flags;

    int total = 0;
    int bad   = 0;

    int          m_cnt;
    logic        m_valid;
    logic [15:0] m_quot;
    logic [3:0]  m_flags;
    logic [19:0] m_pend;
    logic        m_ready;

    bf16_div dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .a           (a),
        .b           (b),
        .ready       (ready),
        .valid_out   (valid_out),
        .quot        (quot),
        .exception   (exception),
        .div_by_zero (div_by_zero),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    assign flags   = {exception, div_by_zero, overflow, underflow};
    assign m_ready = (m_cnt == 0);

    // Returns {exception, div_by_zero, overflow, underflow, quot}.
    function automatic logic [19:0] model_div(input logic [15:0] x, input logic [15:0] y);
        int   ex, ey, e;
        real  r;
        logic s;
        logic [6:0] m;
        s  = x[15] ^ y[15];
        ex = int'(x[14:7]);
        ey = int'(y[14:7]);
        if (ex == 255 || ey == 255) return {4'b1000, 16'h0000};
        if (ey == 0) return {4'b0100, s, 8'hFF, 7'h00};
        if (ex == 0) return {4'b0000, s, 15'h0000};
        r = real'(128 + int'(x[6:0])) / real'(128 + int'(y[6:0]));
        e = ex - ey + 127;
        if (r < 1.0) begin
            r = r * 2.0;
            e = e - 1;
        end
        if (e >= 255) return {4'b0010, s, 8'hFF, 7'h00};
        if (e <= 0) return {4'b0001, s, 15'h0000};
        m = 7'($rtoi((r - 1.0) * 128.0));
        return {4'b0000, s, 8'(e), m};
    endfunction

    // Scoreboard: an accepted request produces its result 10 edges later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt   <= 0;
            m_valid <= 1'b0;
            m_quot  <= 16'h0000;
            m_flags <= 4'h0;
            m_pend  <= 20'h0;
        end else begin
            m_valid <= 1'b0;
            if (m_cnt == 0) begin
                if (start) begin
                    m_pend <= model_div(a, b);
                    m_cnt  <= 10;
                end
            end else begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_valid           <= 1'b1;
                    {m_flags, m_quot} <= m_pend;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, got, want, $time);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("cycle", {10'h0, ready, valid_out, flags, quot},
                    {10'h0, m_ready, m_valid, m_flags, m_quot});
            end
        end
    endtask

    task automatic run_op(input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] eq, input logic [3:0] ef, input string nm);
        int k;
        @(negedge clk);
        a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while (!valid_out && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({nm, " latency"}, 32'(k), 32'd11);
        chk(nm, {12'h0, ef, eq}, {12'h0, flags, quot}) ;
    endtask

    initial begin
        int nv;
        int k;
        logic [15:0] tab_a [5];
        logic [15:0] tab_b [5];
        tab_a = '{16'h40C0, 16'h3F80, 16'hC0C0, 16'h7F80, 16'h4120};
        tab_b = '{16'h4000, 16'h4040, 16'h4000, 16'h3F80, 16'hBF80};

        rst_n = 1'b0; start = 1'b0; a = 16'h0; b = 16'h0;
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        chk("reset outputs", {12'h0, ready, valid_out, flags, quot}, {12'h0, 1'b1, 1'b0, 4'h0, 16'h0});
        rst_n = 1'b1;

        // Pin the reference model on hand-derived values.
        chk("model 6/2", 32'(model_div(16'h40C0, 16'h4000)), 32'h0000_4040);
        chk("model 1/3", 32'(model_div(16'h3F80, 16'h4040)), 32'h0000_3EAA);
        chk("model dz",  32'(model_div(16'h3F80, 16'h0000)), 32'h0004_7F80);
        chk("model ovf", 32'(model_div(16'h7F00, 16'h0080)), 32'h0002_7F80);
        chk("model unf", 32'(model_div(16'h0080, 16'h3FC0)), 32'h0001_0000);

        run_op(16'h3F80, 16'h3F80, 16'h3F80, 4'b0000, "1/1");
        @(negedge clk);
        chk("valid one cycle", {31'h0, valid_out}, 32'h0);
        run_op(16'h40C0, 16'h4000, 16'h4040, 4'b0000, "6/2");
        run_op(16'hC0C0, 16'h4000, 16'hC040, 4'b0000, "-6/2");
        run_op(16'h3F80, 16'h4040, 16'h3EAA, 4'b0000, "1/3");
        run_op(16'h3F80, 16'h0000, 16'h7F80, 4'b0100, "div by zero");
        run_op(16'hBF80, 16'h8000, 16'h7F80, 4'b0100, "neg div by zero");
        run_op(16'h7F80, 16'h3F80, 16'h0000, 4'b1000, "exception a");
        run_op(16'h3F80, 16'hFF80, 16'h0000, 4'b1000, "exception b");
        run_op(16'h0000, 16'h4000, 16'h0000, 4'b0000, "zero a");
        run_op(16'h7F00, 16'h0080, 16'h7F80, 4'b0010, "overflow");
        run_op(16'h7F00, 16'h3F00, 16'h7F80, 4'b0010, "overflow edge");
        run_op(16'h7F7F, 16'h3F80, 16'h7F7F, 4'b0000, "max finite");
        run_op(16'h0080, 16'h7F00, 16'h0000, 4'b0001, "underflow");
        run_op(16'h0080, 16'h3FC0, 16'h0000, 4'b0001, "underflow edge");
        run_op(16'h0080, 16'h3F80, 16'h0080, 4'b0000, "min normal");

        // A start pulse during DIV must be ignored.
        @(negedge clk);
        a = 16'h40C0; b = 16'h4000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        a = 16'h3F80; b = 16'h4040; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 16'h0; b = 16'h0;
        k = 5;
        while (!valid_out && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("busy start latency", 32'(k), 32'd11);
        chk("busy start ignored", {16'h0, quot}, 32'h0000_4040);
        @(negedge clk);

        // Start held high: one accept every 11 cycles.
        nv = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid_out) nv++;
            if (i < 33) begin
                start = 1'b1;
                a = tab_a[i % 5];
                b = tab_b[i % 5];
            end else begin
                start = 1'b0;
            end
        end
        chk("held start results", 32'(nv), 32'd3);

        // Asynchronous reset in the middle of a division.
        @(negedge clk);
        a = 16'h3F80; b = 16'h4040; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk("mid-op reset", {12'h0, ready, valid_out, flags, quot}, {12'h0, 1'b1, 1'b0, 4'h0, 16'h0});
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        nv = 0;
        repeat (12) begin
            @(negedge clk);
            if (valid_out) nv++;
        end
        chk("no stale valid", 32'(nv), 32'd0);
        run_op(16'h40C0, 16'h4000, 16'h4040, 4'b0000, "6/2 after reset");

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
